mux_bit_deserializer: RTL and testbench

- Downstream stage of the NOR-built 2:1 selector.
- Consumes the selector's 1-bit output, one sample per qualified cycle, and assembles WIDTH samples into a parallel word, LSB first.
- Presents each word on a valid/ready output handshake.
- One collecting shift register plus one output holding register, so one word can wait downstream while the next is collected.

---
 rtl/mux_deser_pkg.sv | 16 +
 rtl/mux_deser_out_stage.sv | 46 ++++
 rtl/mux_bit_deserializer.sv | 93 +++++++++
 tb/tb_mux_bit_deserializer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux_deser_pkg.sv
// Shared types and helpers for the selector-output bit deserializer.
package mux_deser_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } mux_deser_state_t;

    localparam int unsigned MUX_DESER_WIDTH_DEF = 8;

    // Bits needed to index one word of the given width.
    function automatic int unsigned mux_deser_cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mux_deser_out_stage.sv
// Output holding register with valid/ready handshake; optional word parity
// is built when MUX_DESER_PARITY_EN is defined.
module mux_deser_out_stage
    import mux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_DESER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
`ifdef MUX_DESER_PARITY_EN
    output logic             word_parity,
`endif
    output logic             free
);

    // Register can accept a new word when empty or being drained this cycle.
    assign free = !word_valid || word_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (load) begin
            word_out   <= load_data;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

`ifdef MUX_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            word_parity <= 1'b0;
        end else if (load) begin
            word_parity <= ^load_data;
        end
    end
`endif

endmodule

// File: rtl/mux_bit_deserializer.sv
// Assembles WIDTH serial samples (LSB first) into words on a valid/ready port.
// Optional parity output is enabled with MUX_DESER_PARITY_EN.
module mux_bit_deserializer
    import mux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_DESER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
`ifdef MUX_DESER_PARITY_EN
    output logic             word_parity,
`endif
    input  logic             word_ready
);

    localparam int unsigned CW = mux_deser_cnt_w(WIDTH);

    mux_deser_state_t state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] shift, shift_nxt;
    logic             load;
    logic             free;

    // Ready depends only on state, so there is no path from word_ready.
    assign bit_ready = (state == COLLECT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
            count <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            shift <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        shift_nxt = shift;
        load      = 1'b0;
        unique case (state)
            COLLECT: begin
                if (bit_valid) begin
                    shift_nxt[count] = bit_in;
                    if (count == CW'(WIDTH - 1)) begin
                        // Completed word either moves out now or parks here.
                        if (free) begin
                            load      = 1'b1;
                            count_nxt = '0;
                        end else begin
                            state_nxt = FULL;
                        end
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            FULL: begin
                if (free) begin
                    load      = 1'b1;
                    count_nxt = '0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    mux_deser_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (shift_nxt),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
`ifdef MUX_DESER_PARITY_EN
        .word_parity(word_parity),
`endif
        .free       (free)
    );

endmodule

// File: tb/tb_mux_bit_deserializer.sv
// Directed and randomized bench for mux_bit_deserializer against a queue-based model.
module tb_mux_bit_deserializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
`ifdef MUX_DESER_PARITY_EN
    logic         word_parity;
`endif

    mux_bit_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
`ifdef MUX_DESER_PARITY_EN
        .word_parity(word_parity),
`endif
        .word_ready (word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: pending samples as a queue, plus the output slot.
    logic         m_bits[$];
    logic [W-1:0] m_out;
    logic         m_valid;
    int           words_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic rst, input logic bv, input logic bi, input logic wr);
        logic         free;
        logic [W-1:0] w;
        if (rst) begin
            m_bits.delete();
            m_out   = '0;
            m_valid = 1'b0;
            return;
        end
        free = !m_valid || wr;
        if (bv && m_bits.size() < W) m_bits.push_back(bi);
        if (m_bits.size() == W && free) begin
            for (int i = 0; i < W; i++) w[i] = m_bits[i];
            m_bits.delete();
            m_out   = w;
            m_valid = 1'b1;
        end else if (m_valid && wr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic bv, input logic bi, input logic wr);
        reset      = rst;
        bit_valid  = bv;
        bit_in     = bi;
        word_ready = wr;
        @(posedge clk);
        model_edge(rst, bv, bi, wr);
        #1;
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("word_out", 32'(word_out), 32'(m_out));
        chk("bit_ready", 32'(bit_ready), 32'(m_bits.size() < W));
`ifdef MUX_DESER_PARITY_EN
        chk("word_parity", 32'(word_parity), 32'(^m_out));
`endif
        if (word_valid) words_seen++;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic wr);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, w[i], wr);
    endtask

    initial begin
        logic [W-1:0] v;
        reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        m_out = '0; m_valid = 1'b0; words_seen = 0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 8'h4D with ready high: one-cycle valid pulse.
        words_seen = 0;
        send_word(8'h4D, 1'b1);
        chk("t1_word", 32'(word_out), 32'h4D);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_pulses", 32'(words_seen), 32'd1);

        // Alternating valid with junk on invalid cycles -> 8'h07.
        v = 8'h07;
        for (int i = 0; i < W; i++) begin
            step(1'b0, 1'b1, v[i], 1'b1);
            if (i == W - 1) chk("t2_word", 32'(word_out), 32'h07);
            step(1'b0, 1'b0, 1'b1, 1'b1);
        end

        // Back-pressure: A5 parks in output, 3C fills the shift register.
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        chk("t3_held", 32'(word_out), 32'hA5);
        chk("t3_full_ready", 32'(bit_ready), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t3_next", 32'(word_out), 32'h3C);
        chk("t3_valid", 32'(word_valid), 32'd1);
        chk("t3_ready", 32'(bit_ready), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back streaming of three words.
        words_seen = 0;
        for (int k = 0; k < 3; k++) send_word(W'($urandom), 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_words", 32'(words_seen), 32'd3);

        // Partial word discarded by reset.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send_word(8'hFF, 1'b1);
        chk("t5_word", 32'(word_out), 32'hFF);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
